// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch sequencer. Holds the fetch PC, issues one
//               request at a time to instruction memory (req/gnt + rvalid),
//               presents each returned instruction with its PC to decode over
//               a valid/ready handshake, and applies redirects from execute,
//               discarding any stale in-flight response.
//               Optional feature macro: FETCH_ALIGN_CHECK_EN
//               (align redirect targets to STEP and flag misaligned ones).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter int            AW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter int            STEP     = 4
) (
    input  logic          CLK,
    input  logic          RST,
    output logic          IMEM_REQ,
    output logic [AW-1:0] IMEM_ADDR,
    input  logic          IMEM_GNT,
    input  logic          IMEM_RVALID,
    input  logic [31:0]   IMEM_RDATA,
    input  logic          REDIRECT,
    input  logic [AW-1:0] REDIRECT_PC,
    output logic          INSTR_VALID,
    output logic [31:0]   INSTR,
    output logic [AW-1:0] INSTR_PC,
    input  logic          INSTR_READY,
    output logic [AW-1:0] PC,
    output logic          MISALIGN
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [AW-1:0] PC_STEP = AW'(STEP);

    state_t        state;
    logic          drop_resp;      // in-flight response belongs to a stale PC
    logic [AW-1:0] redirect_target;
    logic          redirect_misaligned;

`ifdef FETCH_ALIGN_CHECK_EN
    // STEP is a power of two, so STEP-1 selects the low log2(STEP) bits.
    localparam logic [AW-1:0] ALIGN_MASK = PC_STEP - AW'(1);

    // Force redirect targets onto a STEP boundary and remember if we had to.
    always_comb begin
        redirect_target     = REDIRECT_PC & ~ALIGN_MASK;
        redirect_misaligned = |(REDIRECT_PC & ALIGN_MASK);
    end
`else
    // Redirect targets are taken as-is; no misalignment is ever reported.
    always_comb begin
        redirect_target     = REDIRECT_PC;
        redirect_misaligned = 1'b0;
    end
`endif

    // Handshake outputs are decoded from state and masked while in reset.
    always_comb begin
        IMEM_REQ    = (state == ST_FETCH) & ~RST;
        INSTR_VALID = (state == ST_HOLD)  & ~RST;
        IMEM_ADDR   = PC;
    end

    // Fetch sequencer: state, PC, drop flag, instruction register and flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_FETCH;
            PC        <= RESET_PC;
            drop_resp <= 1'b0;
            INSTR     <= '0;
            INSTR_PC  <= '0;
            MISALIGN  <= 1'b0;
        end else begin
            // Every sampled redirect loads PC, so the flag tracks REDIRECT alone.
            MISALIGN <= REDIRECT & redirect_misaligned;

            case (state)
                ST_FETCH: begin
                    if (REDIRECT) begin
                        PC <= redirect_target;
                    end
                    if (IMEM_GNT) begin
                        // A request granted alongside a redirect fetches the
                        // old address; its response must be thrown away.
                        state     <= ST_WAIT;
                        drop_resp <= REDIRECT;
                    end
                end

                ST_WAIT: begin
                    if (IMEM_RVALID) begin
                        if (drop_resp || REDIRECT) begin
                            drop_resp <= 1'b0;
                            if (REDIRECT) begin
                                PC <= redirect_target;
                            end
                            state <= ST_FETCH;
                        end else begin
                            INSTR    <= IMEM_RDATA;
                            INSTR_PC <= PC;
                            PC       <= PC + PC_STEP;
                            state    <= ST_HOLD;
                        end
                    end else if (REDIRECT) begin
                        // Response still pending: retarget now, discard later.
                        PC        <= redirect_target;
                        drop_resp <= 1'b1;
                    end
                end

                ST_HOLD: begin
                    if (REDIRECT) begin
                        PC    <= redirect_target;
                        state <= ST_FETCH;
                    end else if (INSTR_READY) begin
                        state <= ST_FETCH;
                    end
                end

                default: begin
                    state     <= ST_FETCH;
                    drop_resp <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_GNT;
    logic        IMEM_RVALID;
    logic [31:0] IMEM_RDATA;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic        INSTR_VALID;
    logic [31:0] INSTR;
    logic [31:0] INSTR_PC;
    logic        INSTR_READY;
    logic [31:0] PC;
    logic        MISALIGN;

    int total = 0;
    int bad   = 0;

`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic [31:0] EXP_ALIGN_PC  = 32'h0000_0100;
    localparam logic        EXP_MISALIGN  = 1'b1;
`else
    localparam logic [31:0] EXP_ALIGN_PC  = 32'h0000_0102;
    localparam logic        EXP_MISALIGN  = 1'b0;
`endif

    fetch_unit #(
        .AW       (32),
        .RESET_PC (32'h0000_0000),
        .STEP     (4)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .IMEM_REQ    (IMEM_REQ),
        .IMEM_ADDR   (IMEM_ADDR),
        .IMEM_GNT    (IMEM_GNT),
        .IMEM_RVALID (IMEM_RVALID),
        .IMEM_RDATA  (IMEM_RDATA),
        .REDIRECT    (REDIRECT),
        .REDIRECT_PC (REDIRECT_PC),
        .INSTR_VALID (INSTR_VALID),
        .INSTR       (INSTR),
        .INSTR_PC    (INSTR_PC),
        .INSTR_READY (INSTR_READY),
        .PC          (PC),
        .MISALIGN    (MISALIGN)
    );

    always #5 CLK = ~CLK;

    // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        IMEM_GNT    = 1'b0;
        IMEM_RVALID = 1'b0;
        IMEM_RDATA  = 32'h0;
        REDIRECT    = 1'b0;
        REDIRECT_PC = 32'h0;
        INSTR_READY = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        idle_inputs();
        step();
        step();
        total++; if (IMEM_REQ !== 1'b0)     begin bad++; $display("FAIL rst_req: got %b want 0", IMEM_REQ); end
        total++; if (INSTR_VALID !== 1'b0)  begin bad++; $display("FAIL rst_valid: got %b want 0", INSTR_VALID); end
        total++; if (PC !== 32'h0)          begin bad++; $display("FAIL rst_pc: got %h want 0", PC); end
        total++; if (INSTR !== 32'h0)       begin bad++; $display("FAIL rst_instr: got %h want 0", INSTR); end
        total++; if (MISALIGN !== 1'b0)     begin bad++; $display("FAIL rst_misalign: got %b want 0", MISALIGN); end
        RST = 1'b0;
        #1;
        total++; if (IMEM_REQ !== 1'b1)     begin bad++; $display("FAIL first_req: got %b want 1", IMEM_REQ); end
        total++; if (IMEM_ADDR !== 32'h0)   begin bad++; $display("FAIL first_addr: got %h want 0", IMEM_ADDR); end
    endtask

    task automatic test_basic_fetch();
        IMEM_GNT = 1'b1;
        step();
        IMEM_GNT = 1'b0;
        total++; if (IMEM_REQ !== 1'b0)     begin bad++; $display("FAIL basic_wait_req: got %b want 0", IMEM_REQ); end
        IMEM_RVALID = 1'b1; IMEM_RDATA = 32'h1234_5678;
        step();
        IMEM_RVALID = 1'b0;
        total++; if (INSTR_VALID !== 1'b1)  begin bad++; $display("FAIL basic_valid: got %b want 1", INSTR_VALID); end
        total++; if (INSTR !== 32'h1234_5678) begin bad++; $display("FAIL basic_instr: got %h want 12345678", INSTR); end
        total++; if (INSTR_PC !== 32'h0)    begin bad++; $display("FAIL basic_instr_pc: got %h want 0", INSTR_PC); end
        INSTR_READY = 1'b1;
        step();
        INSTR_READY = 1'b0;
        total++; if (INSTR_VALID !== 1'b0)  begin bad++; $display("FAIL basic_valid_drop: got %b want 0", INSTR_VALID); end
        total++; if (IMEM_REQ !== 1'b1)     begin bad++; $display("FAIL basic_next_req: got %b want 1", IMEM_REQ); end
        total++; if (IMEM_ADDR !== 32'h4)   begin bad++; $display("FAIL basic_next_addr: got %h want 4", IMEM_ADDR); end
    endtask

    task automatic test_hold_stall();
        IMEM_GNT = 1'b1;
        step();
        IMEM_GNT = 1'b0;
        IMEM_RVALID = 1'b1; IMEM_RDATA = 32'hA5A5_5A5A;
        step();
        IMEM_RVALID = 1'b0; IMEM_RDATA = 32'hFFFF_0000;
        total++; if (INSTR_PC !== 32'h4)    begin bad++; $display("FAIL stall_instr_pc: got %h want 4", INSTR_PC); end
        for (int i = 0; i < 5; i++) begin
            step();
            total++; if (INSTR_VALID !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d]: got %b want 1", i, INSTR_VALID); end
            total++; if (INSTR !== 32'hA5A5_5A5A) begin bad++; $display("FAIL stall_instr[%0d]: got %h want a5a55a5a", i, INSTR); end
            total++; if (IMEM_REQ !== 1'b0)    begin bad++; $display("FAIL stall_req[%0d]: got %b want 0", i, IMEM_REQ); end
        end
        INSTR_READY = 1'b1;
        step();
        INSTR_READY = 1'b0;
        total++; if (IMEM_ADDR !== 32'h8)   begin bad++; $display("FAIL stall_next_addr: got %h want 8", IMEM_ADDR); end
    endtask

    task automatic test_redirect_on_grant();
        IMEM_GNT = 1'b1; REDIRECT = 1'b1; REDIRECT_PC = 32'h0000_0100;
        step();
        IMEM_GNT = 1'b0; REDIRECT = 1'b0;
        total++; if (IMEM_REQ !== 1'b0)     begin bad++; $display("FAIL rg_wait_req: got %b want 0", IMEM_REQ); end
        total++; if (PC !== 32'h100)        begin bad++; $display("FAIL rg_pc: got %h want 100", PC); end
        IMEM_RVALID = 1'b1; IMEM_RDATA = 32'hDEAD_BEEF;
        step();
        IMEM_RVALID = 1'b0;
        total++; if (INSTR_VALID !== 1'b0)  begin bad++; $display("FAIL rg_valid: got %b want 0", INSTR_VALID); end
        total++; if (INSTR === 32'hDEAD_BEEF) begin bad++; $display("FAIL rg_instr: got %h want not deadbeef", INSTR); end
        total++; if (IMEM_REQ !== 1'b1)     begin bad++; $display("FAIL rg_req: got %b want 1", IMEM_REQ); end
        total++; if (IMEM_ADDR !== 32'h100) begin bad++; $display("FAIL rg_addr: got %h want 100", IMEM_ADDR); end
        step();
        total++; if (INSTR_VALID !== 1'b0)  begin bad++; $display("FAIL rg_valid_late: got %b want 0", INSTR_VALID); end
    endtask

    task automatic test_wrap();
        REDIRECT = 1'b1; REDIRECT_PC = 32'hFFFF_FFFC;
        step();
        REDIRECT = 1'b0;
        total++; if (IMEM_ADDR !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_redir_addr: got %h want fffffffc", IMEM_ADDR); end
        total++; if (IMEM_REQ !== 1'b1)     begin bad++; $display("FAIL wrap_req: got %b want 1", IMEM_REQ); end
        IMEM_GNT = 1'b1;
        step();
        IMEM_GNT = 1'b0;
        IMEM_RVALID = 1'b1; IMEM_RDATA = 32'h0BAD_C0DE;
        step();
        IMEM_RVALID = 1'b0;
        total++; if (INSTR_PC !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_instr_pc: got %h want fffffffc", INSTR_PC); end
        total++; if (INSTR !== 32'h0BAD_C0DE) begin bad++; $display("FAIL wrap_instr: got %h want 0badc0de", INSTR); end
        INSTR_READY = 1'b1;
        step();
        INSTR_READY = 1'b0;
        total++; if (IMEM_ADDR !== 32'h0)   begin bad++; $display("FAIL wrap_addr: got %h want 0", IMEM_ADDR); end
    endtask

    task automatic test_align();
        REDIRECT = 1'b1; REDIRECT_PC = 32'h0000_0102;
        step();
        REDIRECT = 1'b0;
        total++; if (PC !== EXP_ALIGN_PC)   begin bad++; $display("FAIL align_pc: got %h want %h", PC, EXP_ALIGN_PC); end
        total++; if (MISALIGN !== EXP_MISALIGN) begin bad++; $display("FAIL align_flag: got %b want %b", MISALIGN, EXP_MISALIGN); end
        step();
        total++; if (MISALIGN !== 1'b0)     begin bad++; $display("FAIL align_flag_clear: got %b want 0", MISALIGN); end
        REDIRECT = 1'b1; REDIRECT_PC = 32'h0000_0108;
        step();
        REDIRECT = 1'b0;
        total++; if (MISALIGN !== 1'b0)     begin bad++; $display("FAIL align_ok_flag: got %b want 0", MISALIGN); end
        total++; if (PC !== 32'h108)        begin bad++; $display("FAIL align_ok_pc: got %h want 108", PC); end
    endtask

    task automatic test_wait_redirect();
        IMEM_GNT = 1'b1;
        step();
        IMEM_GNT = 1'b0;
        REDIRECT = 1'b1; REDIRECT_PC = 32'h0000_0200;
        step();
        REDIRECT_PC = 32'h0000_0300;
        step();
        REDIRECT = 1'b0;
        total++; if (PC !== 32'h300)        begin bad++; $display("FAIL wr_last_wins: got %h want 300", PC); end
        total++; if (IMEM_REQ !== 1'b0)     begin bad++; $display("FAIL wr_still_wait: got %b want 0", IMEM_REQ); end
        IMEM_RVALID = 1'b1; IMEM_RDATA = 32'h1111_2222;
        step();
        IMEM_RVALID = 1'b0;
        total++; if (INSTR_VALID !== 1'b0)  begin bad++; $display("FAIL wr_discard_valid: got %b want 0", INSTR_VALID); end
        total++; if (IMEM_ADDR !== 32'h300) begin bad++; $display("FAIL wr_addr: got %h want 300", IMEM_ADDR); end
        // Redirect coincident with a live response discards it too.
        IMEM_GNT = 1'b1;
        step();
        IMEM_GNT = 1'b0;
        IMEM_RVALID = 1'b1; IMEM_RDATA = 32'h3333_4444; REDIRECT = 1'b1; REDIRECT_PC = 32'h0000_0400;
        step();
        IMEM_RVALID = 1'b0; REDIRECT = 1'b0;
        total++; if (INSTR_VALID !== 1'b0)  begin bad++; $display("FAIL wr_coinc_valid: got %b want 0", INSTR_VALID); end
        total++; if (IMEM_ADDR !== 32'h400) begin bad++; $display("FAIL wr_coinc_addr: got %h want 400", IMEM_ADDR); end
        total++; if (IMEM_REQ !== 1'b1)     begin bad++; $display("FAIL wr_coinc_req: got %b want 1", IMEM_REQ); end
    endtask

    task automatic test_hold_redirect();
        IMEM_GNT = 1'b1;
        step();
        IMEM_GNT = 1'b0;
        IMEM_RVALID = 1'b1; IMEM_RDATA = 32'h5555_6666;
        step();
        IMEM_RVALID = 1'b0;
        total++; if (INSTR_PC !== 32'h400)  begin bad++; $display("FAIL hr_instr_pc: got %h want 400", INSTR_PC); end
        total++; if (PC !== 32'h404)        begin bad++; $display("FAIL hr_pc_adv: got %h want 404", PC); end
        REDIRECT = 1'b1; REDIRECT_PC = 32'h0000_0500;
        step();
        REDIRECT = 1'b0;
        total++; if (INSTR_VALID !== 1'b0)  begin bad++; $display("FAIL hr_valid: got %b want 0", INSTR_VALID); end
        total++; if (IMEM_ADDR !== 32'h500) begin bad++; $display("FAIL hr_addr: got %h want 500", IMEM_ADDR); end
    endtask

    task automatic test_reset_in_wait();
        IMEM_GNT = 1'b1;
        step();
        IMEM_GNT = 1'b0;
        RST = 1'b1;
        step();
        total++; if (IMEM_REQ !== 1'b0)     begin bad++; $display("FAIL rw_req: got %b want 0", IMEM_REQ); end
        total++; if (INSTR_VALID !== 1'b0)  begin bad++; $display("FAIL rw_valid: got %b want 0", INSTR_VALID); end
        RST = 1'b0;
        #1;
        total++; if (IMEM_REQ !== 1'b1)     begin bad++; $display("FAIL rw_release_req: got %b want 1", IMEM_REQ); end
        total++; if (IMEM_ADDR !== 32'h0)   begin bad++; $display("FAIL rw_release_addr: got %h want 0", IMEM_ADDR); end
    endtask

    initial begin
        RST = 1'b1;
        idle_inputs();
        test_reset();
        test_basic_fetch();
        test_hold_stall();
        test_redirect_on_grant();
        test_wrap();
        test_align();
        test_wait_redirect();
        test_hold_redirect();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
